// File: rtl/axi_tdd_ng_channel_bank.sv
// TDD output channel bank: per-channel on/off windows compared against the shared frame counter,
// with double-buffered configuration that only commits while idle or on the last count of a frame.
package axi_tdd_ng_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        WAITING = 2'b10,
        RUNNING = 2'b11
    } state_t;
endpackage

module axi_tdd_ng_channel_bank
    import axi_tdd_ng_pkg::*;
#(
    parameter int REGISTER_WIDTH = 32,
    parameter int NUM_CH         = 8,
    parameter int NUM_WIN        = 2
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [REGISTER_WIDTH-1:0]                 tdd_counter_i,
    input  state_t                                    tdd_cstate_i,
    input  logic                                      tdd_enable_i,
    input  logic                                      tdd_restart_i,
    input  logic                                      tdd_endof_frame_i,
    input  logic                                      cfg_load_i,
    output logic                                      cfg_pending_o,
    input  logic [NUM_CH-1:0]                         ch_en_i,
    input  logic [NUM_CH-1:0]                         ch_pol_i,
    input  logic [NUM_CH-1:0]                         ch_mode_i,
    input  logic [NUM_CH*NUM_WIN-1:0]                 win_en_i,
    input  logic [NUM_CH*NUM_WIN*REGISTER_WIDTH-1:0]  t_high_i,
    input  logic [NUM_CH*NUM_WIN*REGISTER_WIDTH-1:0]  t_low_i,
    output logic [NUM_CH-1:0]                         out_o
);

    localparam int NW = NUM_CH * NUM_WIN;
    localparam int TW = NW * REGISTER_WIDTH;

    logic [NUM_CH-1:0] ch_en_q;
    logic [NUM_CH-1:0] ch_pol_q;
    logic [NUM_CH-1:0] ch_mode_q;
    logic [NW-1:0]     win_en_q;
    logic [TW-1:0]     t_high_q;
    logic [TW-1:0]     t_low_q;
    logic              cfg_pending_q;

    logic is_idle;
    logic is_running;
    logic commit;

    assign is_idle    = (tdd_cstate_i == IDLE);
    assign is_running = (tdd_cstate_i == RUNNING);
    // A request raised mid-frame waits for the frame boundary so a running frame never glitches.
    assign commit     = (cfg_load_i || cfg_pending_q) && (is_idle || tdd_endof_frame_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ch_en_q       <= '0;
            ch_pol_q      <= '0;
            ch_mode_q     <= '0;
            win_en_q      <= '0;
            t_high_q      <= '0;
            t_low_q       <= '0;
            cfg_pending_q <= 1'b0;
        end else if (commit) begin
            ch_en_q       <= ch_en_i;
            ch_pol_q      <= ch_pol_i;
            ch_mode_q     <= ch_mode_i;
            win_en_q      <= win_en_i;
            t_high_q      <= t_high_i;
            t_low_q       <= t_low_i;
            cfg_pending_q <= 1'b0;
        end else if (cfg_load_i) begin
            cfg_pending_q <= 1'b1;
        end
    end

    assign cfg_pending_o = cfg_pending_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic set_d, set_q;
            logic clr_d, clr_q;
            logic out_q;

            always_comb begin
                set_d = 1'b0;
                clr_d = 1'b0;
                for (int w = 0; w < NUM_WIN; w++) begin
                    if (win_en_q[gi*NUM_WIN + w] &&
                        tdd_counter_i == t_high_q[(gi*NUM_WIN + w)*REGISTER_WIDTH +: REGISTER_WIDTH])
                        set_d = 1'b1;
                    if (win_en_q[gi*NUM_WIN + w] &&
                        tdd_counter_i == t_low_q[(gi*NUM_WIN + w)*REGISTER_WIDTH +: REGISTER_WIDTH])
                        clr_d = 1'b1;
                end
                // Pulse channels end themselves after one cycle, so t_low has no meaning there.
                if (ch_mode_q[gi])
                    clr_d = 1'b0;
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    set_q <= 1'b0;
                    clr_q <= 1'b0;
                    out_q <= 1'b0;
                end else begin
                    set_q <= tdd_enable_i && set_d;
                    clr_q <= tdd_enable_i && clr_d;
                    if (!tdd_enable_i)
                        out_q <= 1'b0;
                    else if (!ch_en_q[gi] || is_idle || clr_q || tdd_restart_i)
                        out_q <= ch_pol_q[gi];
                    else if (is_running && set_q)
                        out_q <= ~ch_pol_q[gi];
                    else if (ch_mode_q[gi])
                        out_q <= ch_pol_q[gi];
                end
            end

            assign out_o[gi] = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_axi_tdd_ng_channel_bank.sv
// Bench for the TDD channel bank: directed vector table, hand-written frame sequences and a
// randomized run against a rule-level reference model.
module tb_axi_tdd_ng_channel_bank;
    import axi_tdd_ng_pkg::*;

    localparam int RW   = 32;
    localparam int NC   = 2;
    localparam int NWIN = 2;
    localparam int NW   = NC * NWIN;
    localparam int TW   = NW * RW;
    localparam int LEN  = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] cnt;
    state_t        cst;
    logic          en, restart, eof, load;
    logic          pending;
    logic [NC-1:0] ch_en, ch_pol, ch_mode, out;
    logic [NW-1:0] win_en;
    logic [TW-1:0] th, tl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_tdd_ng_channel_bank #(.REGISTER_WIDTH(RW), .NUM_CH(NC), .NUM_WIN(NWIN)) dut (
        .clk_i(clk), .rst_i(rst), .tdd_counter_i(cnt), .tdd_cstate_i(cst),
        .tdd_enable_i(en), .tdd_restart_i(restart), .tdd_endof_frame_i(eof),
        .cfg_load_i(load), .cfg_pending_o(pending), .ch_en_i(ch_en), .ch_pol_i(ch_pol),
        .ch_mode_i(ch_mode), .win_en_i(win_en), .t_high_i(th), .t_low_i(tl), .out_o(out)
    );

    typedef struct {
        logic [RW-1:0] cnt;
        state_t        cst;
        logic          en;
        logic          restart;
        logic          eof;
        logic [NC-1:0] exp_out;
    } vec_t;
    vec_t vt[$];

    // Reference model state: active config, pending flag, delayed window hits, outputs.
    logic [NC-1:0] m_en, m_pol, m_mode, m_hs, m_hr, m_out;
    logic [NW-1:0] m_win;
    logic [TW-1:0] m_th, m_tl;
    logic          m_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int k, input state_t s, input logic e, input logic r,
                        input logic f, input logic l);
        cnt = k; cst = s; en = e; restart = r; eof = f; load = l;
        @(posedge clk);
        #1;
        load = 1'b0; restart = 1'b0;
    endtask

    task automatic set_win(input int c, input int w, input logic e, input int hi, input int lo);
        win_en[c*NWIN + w] = e;
        th[(c*NWIN + w)*RW +: RW] = hi;
        tl[(c*NWIN + w)*RW +: RW] = lo;
    endtask

    function automatic vec_t mkv(input int k, input state_t s, input logic e, input logic r,
                                 input logic f, input logic [NC-1:0] o);
        vec_t v;
        v.cnt = k; v.cst = s; v.en = e; v.restart = r; v.eof = f; v.exp_out = o;
        return v;
    endfunction

    function automatic logic any_hit(input int c, input logic [TW-1:0] t, input logic [RW-1:0] k);
        for (int w = 0; w < NWIN; w++)
            if (m_win[c*NWIN + w] && t[(c*NWIN + w)*RW +: RW] == k)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        logic [NC-1:0] no, nhs, nhr;
        logic          cm;
        for (int c = 0; c < NC; c++) begin
            if (!en)
                no[c] = 1'b0;
            else if (!m_en[c] || cst == IDLE || m_hr[c] || restart)
                no[c] = m_pol[c];
            else if (cst == RUNNING && m_hs[c])
                no[c] = ~m_pol[c];
            else if (m_mode[c])
                no[c] = m_pol[c];
            else
                no[c] = m_out[c];
            nhs[c] = en && any_hit(c, m_th, cnt);
            nhr[c] = en && !m_mode[c] && any_hit(c, m_tl, cnt);
        end
        cm = (load || m_pend) && (cst == IDLE || eof);
        if (rst) begin
            m_en = '0; m_pol = '0; m_mode = '0; m_win = '0; m_th = '0; m_tl = '0;
            m_pend = 1'b0; m_hs = '0; m_hr = '0; m_out = '0;
        end else begin
            m_out = no; m_hs = nhs; m_hr = nhr;
            if (cm) begin
                m_en = ch_en; m_pol = ch_pol; m_mode = ch_mode; m_win = win_en;
                m_th = th; m_tl = tl; m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
        end
    endtask

    initial begin
        int pos;
        rst = 1'b1; cnt = '0; cst = IDLE; en = 1'b1; restart = 1'b0; eof = 1'b0; load = 1'b0;
        ch_en = '0; ch_pol = '0; ch_mode = '0; win_en = '0; th = '0; tl = '0;

        step(0, IDLE, 1, 0, 0, 0);
        step(0, IDLE, 1, 0, 0, 1);
        check("reset_out", out, 0);
        check("reset_pending", pending, 0);
        rst = 1'b0;

        // ch0: level window 10..20; ch1: pulse at 5 with t_low=5 that must be ignored.
        ch_en = 2'b11; ch_pol = 2'b00; ch_mode = 2'b10;
        set_win(0, 0, 1, 10, 20);
        set_win(0, 1, 0, 12, 13);
        set_win(1, 0, 1, 5, 5);
        set_win(1, 1, 1, 40, 41);
        step(0, IDLE, 1, 0, 0, 1);
        check("idle_commit_pending", pending, 0);
        check("idle_out", out, 0);

        for (int k = 0; k < 30; k++)
            vt.push_back(mkv(k, RUNNING, 1, 0, k == 29, {k == 6, k >= 11 && k <= 20}));
        for (int k = 0; k < 18; k++)
            vt.push_back(mkv(k, RUNNING, 1, k == 15, 0, {k == 6, k >= 11 && k <= 14}));
        for (int k = 0; k < 14; k++)
            vt.push_back(mkv(k, RUNNING, k != 12, 0, 0, {k == 6, k == 11}));
        vt.push_back(mkv(0, IDLE, 1, 0, 0, 2'b00));
        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].cnt, vt[i].cst, vt[i].en, vt[i].restart, vt[i].eof, 0);
            check($sformatf("table[%0d] cnt=%0d", i, vt[i].cnt), out, vt[i].exp_out);
        end

        // Load mid-frame: stays pending until end of frame, new t_high applies next frame.
        for (int k = 0; k < 30; k++) begin
            if (k == 7) set_win(0, 0, 1, 3, 20);
            step(k, RUNNING, 1, 0, k == 29, k == 7);
            if (k == 7)  check("pend_set", pending, 1);
            if (k == 11) check("pend_old_cfg_out", out[0], 1);
            if (k == 28) check("pend_hold", pending, 1);
            if (k == 29) check("pend_commit_eof", pending, 0);
        end
        for (int k = 0; k < 6; k++) begin
            step(k, RUNNING, 1, 0, 0, 0);
            if (k == 3) check("new_cfg_before", out[0], 0);
            if (k == 4) check("new_cfg_rise", out[0], 1);
        end

        // Overlapping windows: rst at 20 wins, window 1 at 15 does not extend, no rise at 30.
        set_win(0, 0, 1, 10, 20);
        set_win(0, 1, 1, 15, 30);
        step(0, IDLE, 1, 0, 0, 1);
        for (int k = 0; k < 35; k++) begin
            step(k, RUNNING, 1, 0, k == 34, 0);
            if (k == 10 || k == 21 || k == 31 || k == 34) check($sformatf("ovl_low k=%0d", k), out[0], 0);
            if (k == 16 || k == 20) check($sformatf("ovl_high k=%0d", k), out[0], 1);
        end
        set_win(0, 1, 0, 15, 30);

        // t_high == t_low: clear wins, output never leaves polarity.
        set_win(0, 0, 1, 10, 10);
        step(0, IDLE, 1, 0, 0, 1);
        for (int k = 0; k < 16; k++) begin
            step(k, RUNNING, 1, 0, 0, 0);
            if (k == 11 || k == 12) check($sformatf("eq_times k=%0d", k), out[0], 0);
        end

        // Reset mid-window drops output and pending request; config is lost afterwards.
        set_win(0, 0, 1, 10, 20);
        step(0, IDLE, 1, 0, 0, 1);
        for (int k = 0; k < 13; k++) step(k, RUNNING, 1, 0, 0, k == 12);
        check("pre_rst_out", out[0], 1);
        check("pre_rst_pending", pending, 1);
        rst = 1'b1;
        step(13, RUNNING, 1, 0, 0, 0);
        check("rst_out", out, 0);
        check("rst_pending", pending, 0);
        rst = 1'b0;
        for (int k = 0; k < 14; k++) step(k, RUNNING, 1, 0, 0, 0);
        check("rst_cfg_lost", out, 0);

        // Randomized run against the reference model.
        pos = 0;
        for (int i = 0; i < 3000; i++) begin
            rst     = (i == 0) || ($urandom_range(0, 299) == 0);
            cnt     = pos;
            cst     = ($urandom_range(0, 9) == 0) ? IDLE :
                      ($urandom_range(0, 19) == 0) ? WAITING : RUNNING;
            en      = ($urandom_range(0, 19) != 0);
            restart = ($urandom_range(0, 24) == 0);
            eof     = (pos == LEN - 1);
            load    = ($urandom_range(0, 7) == 0);
            if (load) begin
                ch_en = $urandom; ch_pol = $urandom; ch_mode = $urandom; win_en = $urandom;
                for (int j = 0; j < NW; j++) begin
                    th[j*RW +: RW] = $urandom_range(0, LEN + 3);
                    tl[j*RW +: RW] = $urandom_range(0, LEN + 3);
                end
            end
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rand[%0d] out", i), out, m_out);
            check($sformatf("rand[%0d] pending", i), pending, m_pend);
            pos = (pos + 1) % LEN;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
